// File: rtl/logic_shift_unit_pkg.sv
// Shared types for the logic/shift unit: opcodes, FSM states and opcode
// classification helpers.
package lu_pkg;

  localparam int LU_OP_W = 4;

  typedef enum logic [3:0] {
    OP_AND  = 4'd0,
    OP_OR   = 4'd1,
    OP_XOR  = 4'd2,
    OP_NOT  = 4'd3,
    OP_NAND = 4'd4,
    OP_NOR  = 4'd5,
    OP_XNOR = 4'd6,
    OP_PASS = 4'd7,
    OP_SHL  = 4'd8,
    OP_SHR  = 4'd9,
    OP_SAR  = 4'd10,
    OP_ROL  = 4'd11,
    OP_ROR  = 4'd12
  } lu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } lu_state_e;

  function automatic logic is_shift(input logic [LU_OP_W-1:0] op);
    return (op >= OP_SHL) && (op <= OP_ROR);
  endfunction

  // Codes 13..15 are unassigned and produce a zero result with the illegal flag.
  function automatic logic is_illegal(input logic [LU_OP_W-1:0] op);
    return op > OP_ROR;
  endfunction

endpackage

// File: rtl/logic_shift_unit_step.sv
// Combinational datapath: the bitwise result of a/b for ops 0-7 and a
// single one-bit shift/rotate step of r for ops 8-12.
module lu_step
  import lu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [LU_OP_W-1:0] op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   r,
  output logic [WIDTH-1:0]   logic_y,
  output logic [WIDTH-1:0]   step_y
);

  always_comb begin
    logic_y = '0;
    case (op)
      OP_AND:  logic_y = a & b;
      OP_OR:   logic_y = a | b;
      OP_XOR:  logic_y = a ^ b;
      OP_NOT:  logic_y = ~a;
      OP_NAND: logic_y = ~(a & b);
      OP_NOR:  logic_y = ~(a | b);
      OP_XNOR: logic_y = ~(a ^ b);
      OP_PASS: logic_y = b;
      default: logic_y = '0;
    endcase
  end

  // Rotates stay within WIDTH; SAR replicates the current sign bit.
  always_comb begin
    step_y = r;
    case (op)
      OP_SHL:  step_y = {r[WIDTH-2:0], 1'b0};
      OP_SHR:  step_y = {1'b0, r[WIDTH-1:1]};
      OP_SAR:  step_y = {r[WIDTH-1], r[WIDTH-1:1]};
      OP_ROL:  step_y = {r[WIDTH-2:0], r[WIDTH-1]};
      OP_ROR:  step_y = {r[0], r[WIDTH-1:1]};
      default: step_y = r;
    endcase
  end

endmodule

// File: rtl/logic_shift_unit.sv
// Handshaked logic/shift unit: single-cycle bitwise ops, one-bit-per-cycle
// shifts/rotates, result zero-extended to 2*WIDTH with zero/parity/illegal flags.
module logic_shift_unit
  import lu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [LU_OP_W-1:0] opcode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               zero,
  output logic               parity,
  output logic               illegal,
  output logic [1:0]         dbg_state
);

  localparam int SHAMT_W = $clog2(WIDTH);

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // in_ready is high only in IDLE, out_valid only in DONE; the result and
  // flags hold until out_ready is seen with out_valid high.
  lu_state_e            state_q;
  logic [LU_OP_W-1:0]   op_q;
  logic [SHAMT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]     r_q;
  logic                 zero_q;
  logic                 parity_q;
  logic                 illegal_q;

  logic [LU_OP_W-1:0]   op_sel;
  logic [SHAMT_W-1:0]   shamt;
  logic [WIDTH-1:0]     logic_y;
  logic [WIDTH-1:0]     step_y;
  logic [WIDTH-1:0]     accept_r;
  logic                 accept;
  logic                 start_shift;

  assign shamt       = b[SHAMT_W-1:0];
  assign accept      = (state_q == IDLE) && in_valid;
  assign start_shift = is_shift(opcode) && (shamt != '0);
  assign op_sel      = (state_q == IDLE) ? opcode : op_q;
  // A shift by zero completes at accept with the source unchanged.
  assign accept_r    = is_shift(opcode) ? a : logic_y;

  lu_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .op      (op_sel),
    .a       (a),
    .b       (b),
    .r       (r_q),
    .logic_y (logic_y),
    .step_y  (step_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= '0;
      cnt_q     <= '0;
      r_q       <= '0;
      zero_q    <= 1'b0;
      parity_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q <= opcode;
            if (start_shift) begin
              r_q       <= a;
              cnt_q     <= shamt;
              zero_q    <= 1'b0;
              parity_q  <= 1'b0;
              illegal_q <= 1'b0;
              state_q   <= SHIFT;
            end else begin
              r_q       <= accept_r;
              zero_q    <= (accept_r == '0);
              parity_q  <= ^accept_r;
              illegal_q <= is_illegal(opcode);
              state_q   <= DONE;
            end
          end
        end
        SHIFT: begin
          r_q   <= step_y;
          cnt_q <= cnt_q - SHAMT_W'(1);
          if (cnt_q == SHAMT_W'(1)) begin
            zero_q   <= (step_y == '0);
            parity_q <= ^step_y;
            state_q  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // in_ready stays low while reset is held so nothing is accepted then.
  assign in_ready  = !rst && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = {{WIDTH{1'b0}}, r_q};
  assign zero      = zero_q;
  assign parity    = parity_q;
  assign illegal   = illegal_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_logic_shift_unit.sv
// Directed bench for logic_shift_unit at WIDTH=16: bitwise ops, shift latency,
// backpressure, mid-shift reset and illegal opcodes.
module tb_logic_shift_unit;
  import lu_pkg::*;

  localparam int W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      a;
  logic [W-1:0]      b;
  logic [3:0]        opcode;
  logic              out_valid;
  logic              out_ready;
  logic [2*W-1:0]    result;
  logic              zero;
  logic              parity;
  logic              illegal;
  logic [1:0]        dbg_state;

  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   lat;
  logic rdy_seen;
  logic ov_seen;

  logic_shift_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .opcode    (opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .parity    (parity),
    .illegal   (illegal),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Presents one op for a single accept edge, then waits (bounded) for out_valid.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] aa, input logic [W-1:0] bb);
    @(negedge clk);
    check("in_ready_before_accept", in_ready, 1);
    in_valid = 1'b1;
    opcode   = op;
    a        = aa;
    b        = bb;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    opcode   = 4'h0;
    a        = '0;
    b        = '0;
    lat      = 1;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic check_out(input string tag, input int lat_exp, input logic [31:0] res_exp,
                           input logic z_exp, input logic p_exp, input logic il_exp);
    check({tag, "_latency"}, lat, lat_exp);
    check({tag, "_out_valid"}, out_valid, 1);
    check({tag, "_result"}, result, res_exp);
    check({tag, "_zero"}, zero, z_exp);
    check({tag, "_parity"}, parity, p_exp);
    check({tag, "_illegal"}, illegal, il_exp);
  endtask

  task automatic take();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("out_valid_after_take", out_valid, 0);
    check("in_ready_after_take", in_ready, 1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    opcode    = 4'h0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_flags", {zero, parity, illegal}, 3'b000);
    check("rst_state", dbg_state, 2'd0);
    check("rst_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", in_ready, 1);

    run_op(OP_AND, 16'hF0F0, 16'h0FF0);
    check_out("and", 1, 32'h0000_00F0, 1'b0, 1'b0, 1'b0);
    take();

    run_op(OP_XOR, 16'h1234, 16'h00FF);
    check_out("xor", 1, 32'h0000_12CB, 1'b0, 1'b1, 1'b0);
    take();

    run_op(OP_NOR, 16'hFFFF, 16'h0000);
    check_out("nor", 1, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    take();

    run_op(OP_NOT, 16'h5A5A, 16'hFFFF);
    check_out("not", 1, 32'h0000_A5A5, 1'b0, 1'b0, 1'b0);
    take();

    run_op(OP_PASS, 16'h1111, 16'h8001);
    check_out("pass", 1, 32'h0000_8001, 1'b0, 1'b0, 1'b0);
    take();

    run_op(OP_ROL, 16'h8001, 16'h0004);
    check_out("rol4", 5, 32'h0000_0018, 1'b0, 1'b0, 1'b0);
    check("rol4_in_ready_low", rdy_seen, 0);
    take();

    run_op(OP_SAR, 16'h8000, 16'h000F);
    check_out("sar15", 16, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0);
    take();

    run_op(OP_SHL, 16'h1234, 16'h0010);
    check_out("shl0", 1, 32'h0000_1234, 1'b0, 1'b1, 1'b0);
    take();

    run_op(OP_SHR, 16'h8421, 16'hFFF3);
    check_out("shr3", 4, 32'h0000_1084, 1'b0, 1'b1, 1'b0);
    take();

    // Backpressure with a competing request held on the input side
    run_op(OP_NAND, 16'h00FF, 16'h0F0F);
    check_out("nand", 1, 32'h0000_FFF0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      opcode   = OP_OR;
      a        = 16'h0001;
      b        = 16'h0002;
      @(posedge clk);
      #1;
      check("bp_out_valid", out_valid, 1);
      check("bp_result", result, 32'h0000_FFF0);
      check("bp_flags", {zero, parity, illegal}, 3'b000);
      check("bp_in_ready", in_ready, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    take();
    ov_seen = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (out_valid) ov_seen = 1'b1;
    end
    check("bp_not_queued", ov_seen, 0);

    // Asynchronous reset in the middle of a rotate
    run_op(OP_ROR, 16'h00F1, 16'h0008);
    check_out("ror8", 9, 32'h0000_F100, 1'b0, 1'b1, 1'b0);
    take();
    @(negedge clk);
    in_valid = 1'b1;
    opcode   = OP_ROR;
    a        = 16'h00F1;
    b        = 16'h0008;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_result", result, 0);
    check("midrst_state", dbg_state, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1);
    ov_seen = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (out_valid) ov_seen = 1'b1;
    end
    check("midrst_no_stale", ov_seen, 0);

    run_op(4'hE, 16'hFFFF, 16'hFFFF);
    check_out("illegal_e", 1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    take();

    run_op(OP_OR, 16'h0001, 16'h0002);
    check_out("or_after_illegal", 1, 32'h0000_0003, 1'b0, 1'b0, 1'b0);
    take();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
